imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that fills the core's instruction memory over a byte-stream (valid/ready) link and holds the pipelined core in reset until the image is complete. It is the writer for the instruction memory the fetch stage reads. A bench or UART front-end streams a length header plus little-endian instruction bytes. The loader assembles 32-bit words, drives a single-cycle imem write port, then releases the core.

## Interface
- ADDR_W, 8, imem word-address width; DEPTH = 2**ADDR_W words
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  pulse; arms a new load when in IDLE or DONE, ignored otherwise
- byte_valid  input  1  source has a byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  one-cycle imem write strobe
- imem_waddr  output  ADDR_W  word address for the write
- imem_wdata  output  32  assembled instruction word
- core_hold  output  1  drives the core's reset; high until a good load completes
- done  output  1  load finished, with or without error
- err  output  1  header word count exceeded DEPTH
- words_loaded  output  16  count of complete words received

## Operation
- Stream format: byte 0 = count[7:0], byte 1 = count[15:8], then 4*count data bytes, least-significant byte of each word first.
- A byte transfers on a cycle where byte_valid and byte_ready are both high. No other cycle transfers a byte.
- States:
  - IDLE: ready=0. start moves to HDR0, clears words_loaded, err and done, and sets core_hold=1.
  - HDR0: ready=1. A transfer latches count[7:0] and moves to HDR1.
  - HDR1: ready=1. A transfer latches count[15:8]. If count > DEPTH, set err. If count==0, move to DONE; otherwise move to DATA.
  - DATA: ready=1. A 2-bit byte index places each byte into lane idx of the word buffer. On the lane-3 transfer:
    - register imem_we=1, imem_waddr=word index[ADDR_W-1:0], imem_wdata=assembled word;
    - increment words_loaded.
    - When words_loaded reaches count, move to DONE.
  - DONE: ready=0. done=1. start re-arms to HDR0.
- Word indices ≥ DEPTH (possible only when err is set) are consumed but produce no imem_we.
- The loader never writes past the end of memory. words_loaded still counts these words.
- core_hold falls only in DONE with err=0. With err=1 the core stays held.
- start in HDR0, HDR1 or DATA is ignored. start coincident with a byte transfer in DONE or IDLE arms only; that byte is not consumed, because ready=0.
- When reset asserts mid-load, all outputs take reset values immediately. imem contents are untouched; the partial image stays in memory, and core_hold=1 keeps it from running.

## Timing
- Reset values: state IDLE, byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_hold=1, done=0, err=0, words_loaded=0.
- byte_ready is a registered function of state. There is no backpressure inside a load, so back-to-back bytes sustain one byte per cycle.
- Write latency: imem_we is high for exactly the one cycle following the edge that accepted lane 3. imem captures the word on the next edge.
- Final word: the state enters DONE on the same edge that asserts imem_we. done rises and core_hold falls one edge later, so the last write is committed before the core leaves reset.
- count==0: done rises one cycle after DONE is entered, and no writes occur.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (IDLE, HDR0, HDR1, DATA, DONE);
  - the header byte count constant (2);
  - the bytes-per-word constant (4).
- Single module; no sub-module. Word assembly is a 4×8 shift/lane register inside the block.

## Test plan
- Reset then start, then stream 02 00 | 13 05 10 00 | 93 05 20 00:
  - imem_we pulses twice: addr 0 data 0x00100513, then addr 1 data 0x00200593;
  - words_loaded=2, done=1, core_hold=0, err=0.
- Same stream with byte_valid gapped every other cycle: identical writes and values, with each imem_we one cycle after its 4th byte.
- Stream 00 00 after start: no imem_we, done=1, core_hold=0, words_loaded=0.
- ADDR_W=2, header 05 00 plus 20 bytes:
  - err=1 after the header;
  - writes at addresses 0–3 only; the fifth word is consumed with no imem_we;
  - words_loaded=5, done=1, core_hold stays 1.
- Assert reset after 6 data bytes of a 3-word load:
  - all outputs return to reset values asynchronously, and the state is IDLE;
  - a subsequent start plus a full stream loads correctly from addr 0.
- Pulse start in DATA: ignored, and the load completes unchanged. Pulse start in DONE: returns to HDR0, done=0, core_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time instruction memory loader.
//   state_e        : loader FSM states
//   HDR_BYTES      : number of length-header bytes preceding the image
//   BYTES_PER_WORD : stream bytes assembled into one instruction word
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE} state_e;
    localparam int HDR_BYTES = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams a length header plus little-endian words into imem and holds the core until done.
//   clk_i / reset_i         : clock, asynchronous active-high reset
//   start_i                 : arms a new load from IDLE or DONE
//   byte_valid_i/byte_data_i: byte stream in, byte_ready_o accepts it
//   imem_we_o/waddr_o/wdata_o : single-cycle imem write port
//   core_hold_o             : core reset, released only after an error-free load
//   done_o / err_o          : load finished / header count exceeded memory depth
//   words_loaded_o          : complete words received in this load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_waddr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       words_loaded_o
);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    state_e            state_q, state_d;
    logic [15:0]       count_q, count_d, words_q, words_d;
    logic [2:0][7:0]   lanes_q, lanes_d;
    logic [1:0]        idx_q, idx_d;
    logic              ready_q, ready_d, we_q, we_d, hold_q, hold_d;
    logic              done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              xfer, arm, last, data_x;
    logic [15:0]       hdr_count, words_inc;

    assign xfer      = byte_valid_i & ready_q;
    assign arm       = start_i & (state_q == IDLE || state_q == DONE);
    assign last      = idx_q == 2'(BYTES_PER_WORD - 1);
    assign data_x    = xfer & (state_q == DATA);
    assign hdr_count = {byte_data_i, count_q[7:0]};
    assign words_inc = words_q + 16'd1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = start_i ? HDR0 : state_q;
            HDR0:       state_d = xfer ? HDR1 : HDR0;
            HDR1:       state_d = !xfer ? HDR1 : (hdr_count == 16'd0) ? DONE : DATA;
            DATA:       state_d = (data_x && last && words_inc == count_q) ? DONE : DATA;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath next-state; arm takes priority so a restart always begins from a clean slate.
    always_comb begin
        lanes_d = lanes_q;
        if (data_x && !last) lanes_d[idx_q] = byte_data_i;
        count_d = (xfer && state_q == HDR0) ? {count_q[15:8], byte_data_i} :
                  (xfer && state_q == HDR1) ? hdr_count : count_q;
        idx_d   = arm ? 2'd0 : data_x ? idx_q + 2'd1 : idx_q;
        // Words past the end of memory are counted but never written.
        we_d    = data_x && last && ({1'b0, words_q} < DEPTH);
        waddr_d = we_d ? words_q[ADDR_W-1:0] : waddr_q;
        wdata_d = we_d ? {byte_data_i, lanes_q} : wdata_q;
        words_d = arm ? 16'd0 : (data_x && last) ? words_inc : words_q;
        err_d   = arm ? 1'b0 : (xfer && state_q == HDR1 && {1'b0, hdr_count} > DEPTH) ? 1'b1 : err_q;
        // done/hold follow DONE by one edge so the final write commits before release.
        done_d  = arm ? 1'b0 : (state_q == DONE) ? 1'b1 : done_q;
        hold_d  = arm ? 1'b1 : (state_q == DONE && !err_q) ? 1'b0 : hold_q;
        ready_d = state_d == HDR0 || state_d == HDR1 || state_d == DATA;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            words_q <= '0;
            lanes_q <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            words_q <= words_d;
            lanes_q <= lanes_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready_o   = ready_q;
    assign imem_we_o      = we_q;
    assign imem_waddr_o   = waddr_q;
    assign imem_wdata_o   = wdata_q;
    assign core_hold_o    = hold_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader at ADDR_W=8 and ADDR_W=2.
module tb_imem_loader;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, bv = 1'b0, sel = 1'b0;
    logic [7:0]  bd = 8'h00;
    logic        r8, we8, h8, d8, e8, r2, we2, h2, d2, e2;
    logic [7:0]  wa8;
    logic [1:0]  wa2;
    logic [31:0] wd8, wd2;
    logic [15:0] wl8, wl2;
    logic        rdy, dn, hd, er;
    logic [15:0] wl;
    int          cyc = 0, total = 0, passed = 0;

    typedef struct {int addr; logic [31:0] data; int c;} wr_t;
    wr_t q8[$], q2[$];
    wr_t e8w, e2w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdy = sel ? r2 : r8;
    assign dn  = sel ? d2 : d8;
    assign hd  = sel ? h2 : h8;
    assign er  = sel ? e2 : e8;
    assign wl  = sel ? wl2 : wl8;

    imem_loader #(.ADDR_W(8)) u8 (
        .clk_i(clk), .reset_i(rst), .start_i(start & ~sel), .byte_valid_i(bv & ~sel), .byte_data_i(bd),
        .byte_ready_o(r8), .imem_we_o(we8), .imem_waddr_o(wa8), .imem_wdata_o(wd8),
        .core_hold_o(h8), .done_o(d8), .err_o(e8), .words_loaded_o(wl8));

    imem_loader #(.ADDR_W(2)) u2 (
        .clk_i(clk), .reset_i(rst), .start_i(start & sel), .byte_valid_i(bv & sel), .byte_data_i(bd),
        .byte_ready_o(r2), .imem_we_o(we2), .imem_waddr_o(wa2), .imem_wdata_o(wd2),
        .core_hold_o(h2), .done_o(d2), .err_o(e2), .words_loaded_o(wl2));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    always @(negedge clk) if (we8 === 1'b1) begin
        if (q8.size() == 0) begin
            total++;
            $display("FAIL u8 unexpected write: addr %0d data %h", wa8, wd8);
        end else begin
            e8w = q8.pop_front();
            chk("u8 waddr", 32'(wa8), 32'(e8w.addr));
            chk("u8 wdata", wd8, e8w.data);
            chk("u8 write cycle", 32'(cyc), 32'(e8w.c));
        end
    end

    always @(negedge clk) if (we2 === 1'b1) begin
        if (q2.size() == 0) begin
            total++;
            $display("FAIL u2 unexpected write: addr %0d data %h", wa2, wd2);
        end else begin
            e2w = q2.pop_front();
            chk("u2 waddr", 32'(wa2), 32'(e2w.addr));
            chk("u2 wdata", wd2, e2w.data);
            chk("u2 write cycle", 32'(cyc), 32'(e2w.c));
        end
    end

    // Drives one byte; when wr is set, the write it completes is queued one cycle after acceptance.
    task automatic send(input logic [7:0] b, input bit gap, input bit wr, input int addr, input logic [31:0] data);
        int n;
        wr_t w;
        @(negedge clk);
        bd = b;
        bv = 1'b1;
        n = 0;
        while (rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            total++;
            $display("FAIL byte accept timeout: byte %h ready %b", b, rdy);
        end
        if (wr) begin
            w.addr = addr;
            w.data = data;
            w.c = cyc + 1;
            if (sel) q2.push_back(w);
            else q8.push_back(w);
        end
        @(posedge clk);
        if (gap) begin
            @(negedge clk);
            bv = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int addr, input bit wr, input bit gap);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap, wr && i == 3, addr, w);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bv = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic end_chk(input bit gapped, input logic [15:0] w, input logic e, input logic h);
        if (!gapped) @(negedge clk);
        chk("done before commit", 32'(dn), 32'd0);
        chk("hold before commit", 32'(hd), 32'd1);
        @(negedge clk);
        chk("done", 32'(dn), 32'd1);
        chk("core_hold", 32'(hd), 32'(h));
        chk("err", 32'(er), 32'(e));
        chk("words_loaded", 32'(wl), 32'(w));
        chk("ready in DONE", 32'(rdy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(r8), 32'd0);
        chk("rst we", 32'(we8), 32'd0);
        chk("rst waddr", 32'(wa8), 32'd0);
        chk("rst wdata", wd8, 32'd0);
        chk("rst hold", 32'(h8), 32'd1);
        chk("rst done", 32'(d8), 32'd0);
        chk("rst err", 32'(e8), 32'd0);
        chk("rst words", 32'(wl8), 32'd0);
        chk("rst u2 hold", 32'(h2), 32'd1);
        rst = 1'b0;

        // Two-word load, back-to-back bytes
        pulse_start();
        chk("armed ready", 32'(rdy), 32'd1);
        chk("armed hold", 32'(hd), 32'd1);
        send(8'h02, 0, 0, 0, 0);
        send(8'h00, 0, 0, 0, 0);
        send_word(32'h00100513, 0, 1, 0);
        send_word(32'h00200593, 1, 1, 0);
        end_chk(0, 16'd2, 1'b0, 1'b0);

        // Same image with a gap after every byte
        pulse_start();
        chk("rearm done", 32'(dn), 32'd0);
        chk("rearm hold", 32'(hd), 32'd1);
        chk("rearm words", 32'(wl), 32'd0);
        send(8'h02, 1, 0, 0, 0);
        send(8'h00, 1, 0, 0, 0);
        send_word(32'h00100513, 0, 1, 1);
        send_word(32'h00200593, 1, 1, 1);
        end_chk(1, 16'd2, 1'b0, 1'b0);

        // Empty image
        pulse_start();
        send(8'h00, 0, 0, 0, 0);
        send(8'h00, 0, 0, 0, 0);
        end_chk(0, 16'd0, 1'b0, 1'b0);

        // Reset in the middle of a three-word load
        pulse_start();
        send(8'h03, 0, 0, 0, 0);
        send(8'h00, 0, 0, 0, 0);
        send_word(32'hA1B2C3D4, 0, 1, 0);
        send(8'h11, 0, 0, 0, 0);
        send(8'h22, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async ready", 32'(r8), 32'd0);
        chk("async we", 32'(we8), 32'd0);
        chk("async waddr", 32'(wa8), 32'd0);
        chk("async wdata", wd8, 32'd0);
        chk("async hold", 32'(h8), 32'd1);
        chk("async done", 32'(d8), 32'd0);
        chk("async err", 32'(e8), 32'd0);
        chk("async words", 32'(wl8), 32'd0);
        @(negedge clk);
        bv = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", 32'(r8), 32'd0);
        pulse_start();
        send(8'h03, 0, 0, 0, 0);
        send(8'h00, 0, 0, 0, 0);
        send_word(32'h0A0B0C0D, 0, 1, 0);
        pulse_start();
        chk("start in DATA ready", 32'(rdy), 32'd1);
        chk("start in DATA words", 32'(wl), 32'd1);
        chk("start in DATA done", 32'(dn), 32'd0);
        send_word(32'h12345678, 1, 1, 0);
        send_word(32'hCAFEF00D, 2, 1, 0);
        end_chk(0, 16'd3, 1'b0, 1'b0);

        // Start in DONE re-arms
        pulse_start();
        chk("DONE start ready", 32'(rdy), 32'd1);
        chk("DONE start done", 32'(dn), 32'd0);
        chk("DONE start hold", 32'(hd), 32'd1);
        send(8'h00, 0, 0, 0, 0);
        send(8'h00, 0, 0, 0, 0);
        end_chk(0, 16'd0, 1'b0, 1'b0);

        // Oversized image into a 4-word memory
        @(negedge clk);
        sel = 1'b1;
        pulse_start();
        send(8'h05, 0, 0, 0, 0);
        send(8'h00, 0, 0, 0, 0);
        #1 chk("err after header", 32'(er), 32'd1);
        for (int i = 0; i < 5; i++) send_word(32'hA5000000 + 32'(i), i, i < 4, 0);
        end_chk(0, 16'd5, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("u8 writes drained", 32'(q8.size()), 32'd0);
        chk("u2 writes drained", 32'(q2.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
